// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory: NOP clear after reset, streaming loader,
// 1-cycle registered fetch with stall hold and fault flags. Optional parity: INSTR_MEM_PARITY_EN.
module instr_mem_loadable #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 128,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  Clk,
  input  logic                  RstN,
  input  logic                  FetchReq,
  input  logic                  FetchStall,
  input  logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  InstrValid,
  output logic                  AddrFault,
  input  logic                  LoadStart,
  input  logic                  LoadValid,
  input  logic [DATA_WIDTH-1:0] LoadData,
  input  logic                  LoadEnd,
  output logic                  LoadReady,
  output logic                  LoadDone,
  output logic                  Busy,
  output logic                  ParityErr
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  // Loader handshake: a word transfers on every edge where LoadValid && LoadReady.
  // LoadReady is high for the whole LOAD state; LoadEnd may arrive with or without a word.
  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;

  state_t              state, state_next;
  logic [IW-1:0]       ptr, ptr_next;
  logic                load_end;
  logic                wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]       fetch_idx;
  logic                addr_ok;
  logic                par_bad;

  assign fetch_idx = Address[IW+1:2];
  assign addr_ok   = (Address[1:0] == 2'b00) && ((Address >> (IW + 2)) == '0);
  assign Busy      = (state != RUN);
  assign LoadReady = (state == LOAD);

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // One pointer serves both the clear sweep and the load stream.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    load_end   = 1'b0;
    wr_en      = 1'b0;
    wr_data    = NOP_WORD;
    case (state)
      CLEAR: begin
        wr_en    = 1'b1;
        ptr_next = ptr + 1'b1;
        if (ptr == LAST_IDX) state_next = RUN;
      end
      RUN: begin
        if (LoadStart) begin
          state_next = LOAD;
          ptr_next   = '0;
        end
      end
      LOAD: begin
        if (LoadValid) begin
          wr_en    = 1'b1;
          wr_data  = LoadData;
          ptr_next = ptr + 1'b1;
        end
        if ((LoadValid && (ptr == LAST_IDX)) || LoadEnd) begin
          load_end   = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (wr_en) mem[ptr] <= wr_data;
  end

`ifdef INSTR_MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (wr_en) par_mem[ptr] <= ^wr_data;
  end

  assign par_bad = (^mem[fetch_idx]) != par_mem[fetch_idx];
`else
  assign par_bad = 1'b0;
`endif

  // Fetch outputs only move in RUN; a LoadStart cycle drops InstrValid even under stall.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      Instruction <= NOP_WORD;
      InstrValid  <= 1'b0;
      AddrFault   <= 1'b0;
      ParityErr   <= 1'b0;
      LoadDone    <= 1'b0;
    end else begin
      LoadDone <= load_end;
      if (state == RUN) begin
        if (LoadStart) begin
          InstrValid <= 1'b0;
        end else if (!FetchStall) begin
          InstrValid <= FetchReq;
          if (FetchReq && addr_ok) begin
            Instruction <= par_bad ? NOP_WORD : mem[fetch_idx];
            AddrFault   <= 1'b0;
            ParityErr   <= par_bad;
          end else if (FetchReq) begin
            Instruction <= NOP_WORD;
            AddrFault   <= 1'b1;
            ParityErr   <= 1'b0;
          end else begin
            AddrFault   <= 1'b0;
            ParityErr   <= 1'b0;
          end
        end
      end else begin
        InstrValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: directed scenarios plus randomized load/fetch traffic
// checked against a word-array reference model of the memory.
module tb_instr_mem_loadable;

  localparam int          DEPTH = 128;
  localparam int          IW    = 7;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        RstN = 1'b0;
  logic        FetchReq = 1'b0;
  logic        FetchStall = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        AddrFault;
  logic        LoadStart = 1'b0;
  logic        LoadValid = 1'b0;
  logic [31:0] LoadData = '0;
  logic        LoadEnd = 1'b0;
  logic        LoadReady;
  logic        LoadDone;
  logic        Busy;
  logic        ParityErr;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];

  instr_mem_loadable dut (
    .Clk(Clk), .RstN(RstN), .FetchReq(FetchReq), .FetchStall(FetchStall),
    .Address(Address), .Instruction(Instruction), .InstrValid(InstrValid),
    .AddrFault(AddrFault), .LoadStart(LoadStart), .LoadValid(LoadValid),
    .LoadData(LoadData), .LoadEnd(LoadEnd), .LoadReady(LoadReady),
    .LoadDone(LoadDone), .Busy(Busy), .ParityErr(ParityErr)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic ref_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (ref_fault(a)) return NOP;
    return model_mem[a[IW+1:2]];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
  endtask

  task automatic test_reset();
    int cycles;
    RstN = 1'b0; FetchReq = 1'b1; Address = 32'h10;
    repeat (2) tick();
    n_checks++; if (Instruction !== NOP) begin n_errors++; $display("FAIL reset_instr: got %h expected %h", Instruction, NOP); end
    n_checks++; if (InstrValid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", InstrValid); end
    n_checks++; if (AddrFault !== 1'b0) begin n_errors++; $display("FAIL reset_fault: got %b expected 0", AddrFault); end
    n_checks++; if (LoadReady !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", LoadReady); end
    n_checks++; if (LoadDone !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", LoadDone); end
    n_checks++; if (ParityErr !== 1'b0) begin n_errors++; $display("FAIL reset_parity: got %b expected 0", ParityErr); end
    n_checks++; if (Busy !== 1'b1) begin n_errors++; $display("FAIL reset_busy: got %b expected 1", Busy); end
    RstN = 1'b1;
    cycles = 0;
    while (Busy === 1'b1 && cycles < 300) begin
      n_checks++; if (InstrValid !== 1'b0) begin n_errors++; $display("FAIL clear_valid: got %b expected 0 at cycle %0d", InstrValid, cycles); end
      tick();
      cycles++;
    end
    n_checks++; if (cycles != DEPTH) begin n_errors++; $display("FAIL clear_cycles: got %0d expected %0d", cycles, DEPTH); end
    model_clear();
    tick();
    n_checks++; if (InstrValid !== 1'b1) begin n_errors++; $display("FAIL first_fetch_valid: got %b expected 1", InstrValid); end
    n_checks++; if (Instruction !== ref_word(32'h10)) begin n_errors++; $display("FAIL first_fetch_instr: got %h expected %h", Instruction, ref_word(32'h10)); end
    n_checks++; if (AddrFault !== 1'b0) begin n_errors++; $display("FAIL first_fetch_fault: got %b expected 0", AddrFault); end
    FetchReq = 1'b0;
    tick();
  endtask

  task automatic test_load_end();
    logic [31:0] words [3];
    logic [31:0] addrs [4];
    words = '{32'h3412_0000, 32'h8e52_0000, 32'h3413_0000};
    addrs = '{32'h0, 32'h4, 32'h8, 32'hC};
    LoadStart = 1'b1;
    tick();
    LoadStart = 1'b0;
    n_checks++; if (LoadReady !== 1'b1) begin n_errors++; $display("FAIL load_ready: got %b expected 1", LoadReady); end
    n_checks++; if (Busy !== 1'b1) begin n_errors++; $display("FAIL load_busy: got %b expected 1", Busy); end
    for (int i = 0; i < 3; i++) begin
      LoadValid = 1'b1; LoadData = words[i]; LoadEnd = (i == 2);
      tick();
      model_mem[i] = words[i];
      if (i < 2) begin
        n_checks++; if (LoadDone !== 1'b0) begin n_errors++; $display("FAIL load_done_early: got %b expected 0 word %0d", LoadDone, i); end
      end
    end
    LoadValid = 1'b0; LoadEnd = 1'b0;
    n_checks++; if (LoadDone !== 1'b1) begin n_errors++; $display("FAIL load_done: got %b expected 1", LoadDone); end
    n_checks++; if (LoadReady !== 1'b0) begin n_errors++; $display("FAIL load_ready_end: got %b expected 0", LoadReady); end
    n_checks++; if (Busy !== 1'b0) begin n_errors++; $display("FAIL load_busy_end: got %b expected 0", Busy); end
    tick();
    n_checks++; if (LoadDone !== 1'b0) begin n_errors++; $display("FAIL load_done_pulse: got %b expected 0", LoadDone); end
    for (int i = 0; i < 4; i++) begin
      FetchReq = 1'b1; Address = addrs[i];
      tick();
      n_checks++; if (Instruction !== ref_word(addrs[i])) begin n_errors++; $display("FAIL fetch_loaded %h: got %h expected %h", addrs[i], Instruction, ref_word(addrs[i])); end
      n_checks++; if (InstrValid !== 1'b1) begin n_errors++; $display("FAIL fetch_loaded_valid %h: got %b expected 1", addrs[i], InstrValid); end
    end
    FetchReq = 1'b0;
    tick();
  endtask

  task automatic test_faults();
    logic [31:0] addrs [2];
    addrs = '{32'h6, 32'h200};
    for (int i = 0; i < 2; i++) begin
      FetchReq = 1'b1; Address = addrs[i];
      tick();
      n_checks++; if (Instruction !== NOP) begin n_errors++; $display("FAIL fault_instr %h: got %h expected %h", addrs[i], Instruction, NOP); end
      n_checks++; if (AddrFault !== 1'b1) begin n_errors++; $display("FAIL fault_flag %h: got %b expected 1", addrs[i], AddrFault); end
      n_checks++; if (InstrValid !== 1'b1) begin n_errors++; $display("FAIL fault_valid %h: got %b expected 1", addrs[i], InstrValid); end
    end
    Address = 32'h4;
    tick();
    n_checks++; if (AddrFault !== 1'b0) begin n_errors++; $display("FAIL fault_clear: got %b expected 0", AddrFault); end
    n_checks++; if (Instruction !== ref_word(32'h4)) begin n_errors++; $display("FAIL fault_clear_instr: got %h expected %h", Instruction, ref_word(32'h4)); end
    FetchReq = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] held;
    FetchReq = 1'b1; Address = 32'h4;
    tick();
    held = ref_word(32'h4);
    FetchStall = 1'b1; Address = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (Instruction !== held) begin n_errors++; $display("FAIL stall_instr cycle %0d: got %h expected %h", i, Instruction, held); end
      n_checks++; if (InstrValid !== 1'b1) begin n_errors++; $display("FAIL stall_valid cycle %0d: got %b expected 1", i, InstrValid); end
    end
    FetchStall = 1'b0;
    tick();
    n_checks++; if (Instruction !== ref_word(32'h8)) begin n_errors++; $display("FAIL stall_release: got %h expected %h", Instruction, ref_word(32'h8)); end
    FetchReq = 1'b0;
    tick();
    n_checks++; if (InstrValid !== 1'b0) begin n_errors++; $display("FAIL idle_valid: got %b expected 0", InstrValid); end
    n_checks++; if (Instruction !== ref_word(32'h8)) begin n_errors++; $display("FAIL idle_hold: got %h expected %h", Instruction, ref_word(32'h8)); end
  endtask

  task automatic test_full_load();
    LoadStart = 1'b1;
    tick();
    LoadStart = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        LoadValid = 1'b0;
        tick();
        n_checks++; if (Busy !== 1'b1) begin n_errors++; $display("FAIL full_gap_busy word %0d: got %b expected 1", i, Busy); end
      end
      LoadValid = 1'b1; LoadData = 32'(i * 4);
      tick();
      model_mem[i] = 32'(i * 4);
      if (i < DEPTH - 1) begin
        n_checks++; if (LoadDone !== 1'b0) begin n_errors++; $display("FAIL full_done_early word %0d: got %b expected 0", i, LoadDone); end
      end
    end
    LoadValid = 1'b0;
    n_checks++; if (LoadDone !== 1'b1) begin n_errors++; $display("FAIL full_done: got %b expected 1", LoadDone); end
    n_checks++; if (Busy !== 1'b0) begin n_errors++; $display("FAIL full_busy: got %b expected 0", Busy); end
    FetchReq = 1'b1; Address = 32'h1FC;
    tick();
    n_checks++; if (Instruction !== ref_word(32'h1FC)) begin n_errors++; $display("FAIL full_fetch_last: got %h expected %h", Instruction, ref_word(32'h1FC)); end
    Address = 32'h0;
    tick();
    n_checks++; if (Instruction !== ref_word(32'h0)) begin n_errors++; $display("FAIL full_fetch_first: got %h expected %h", Instruction, ref_word(32'h0)); end
    FetchReq = 1'b0;
    tick();
  endtask

  task automatic test_random_traffic();
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic        exp_fault;
    logic [31:0] got_exp;
    int          n;
    logic        end_with_word;
    for (int round = 0; round < 3; round++) begin
      LoadStart = 1'b1;
      tick();
      LoadStart = 1'b0;
      n = $urandom_range(1, 12);
      end_with_word = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          LoadValid = 1'b0;
          tick();
        end
        LoadValid = 1'b1; LoadData = $urandom; LoadEnd = end_with_word && (i == n - 1);
        model_mem[i] = LoadData;
        tick();
      end
      if (!end_with_word) begin
        LoadValid = 1'b0; LoadEnd = 1'b1;
        tick();
      end
      LoadValid = 1'b0; LoadEnd = 1'b0;
      n_checks++; if (LoadDone !== 1'b1) begin n_errors++; $display("FAIL rand_load_done round %0d: got %b expected 1", round, LoadDone); end
      FetchStall = 1'b0; FetchReq = 1'b1; Address = 32'h0;
      tick();
      exp_instr = ref_word(32'h0); exp_valid = 1'b1; exp_fault = 1'b0;
      for (int c = 0; c < 60; c++) begin
        FetchStall = ($urandom_range(0, 3) == 0);
        FetchReq = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0, 1: Address = $urandom_range(0, DEPTH - 1) * 4;
          2: Address = $urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3);
          default: Address = $urandom_range(32'h200, 32'hFFFF_FFFF);
        endcase
        if (!FetchStall) begin
          exp_valid = FetchReq;
          if (FetchReq) begin
            exp_instr = ref_word(Address);
            exp_fault = ref_fault(Address);
          end else begin
            exp_fault = 1'b0;
          end
        end
        exp_q.push_back(exp_instr);
        tick();
        got_exp = exp_q.pop_front();
        n_checks++; if (Instruction !== got_exp) begin n_errors++; $display("FAIL rand_instr r%0d c%0d: got %h expected %h", round, c, Instruction, got_exp); end
        n_checks++; if (InstrValid !== exp_valid) begin n_errors++; $display("FAIL rand_valid r%0d c%0d: got %b expected %b", round, c, InstrValid, exp_valid); end
        n_checks++; if (AddrFault !== exp_fault) begin n_errors++; $display("FAIL rand_fault r%0d c%0d: got %b expected %b", round, c, AddrFault, exp_fault); end
        n_checks++; if (ParityErr !== 1'b0) begin n_errors++; $display("FAIL rand_parity r%0d c%0d: got %b expected 0", round, c, ParityErr); end
      end
      FetchStall = 1'b0; FetchReq = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid_load();
    int cycles;
    FetchReq = 1'b1; Address = 32'h1FC;
    tick();
    FetchReq = 1'b0;
    LoadStart = 1'b1;
    tick();
    LoadStart = 1'b0;
    LoadValid = 1'b1; LoadData = 32'hDEAD_BEEF;
    tick();
    LoadData = 32'hCAFE_F00D;
    #3;
    RstN = 1'b0;
    #1;
    n_checks++; if (Instruction !== NOP) begin n_errors++; $display("FAIL midrst_instr: got %h expected %h", Instruction, NOP); end
    n_checks++; if (LoadReady !== 1'b0) begin n_errors++; $display("FAIL midrst_ready: got %b expected 0", LoadReady); end
    n_checks++; if (Busy !== 1'b1) begin n_errors++; $display("FAIL midrst_busy: got %b expected 1", Busy); end
    n_checks++; if (InstrValid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b expected 0", InstrValid); end
    LoadValid = 1'b0;
    model_clear();
    repeat (2) tick();
    RstN = 1'b1;
    cycles = 0;
    while (Busy === 1'b1 && cycles < 300) begin
      tick();
      cycles++;
    end
    n_checks++; if (cycles != DEPTH) begin n_errors++; $display("FAIL midrst_clear_cycles: got %0d expected %0d", cycles, DEPTH); end
    FetchReq = 1'b1; Address = 32'h0;
    tick();
    n_checks++; if (Instruction !== ref_word(32'h0)) begin n_errors++; $display("FAIL midrst_fetch0: got %h expected %h", Instruction, ref_word(32'h0)); end
    Address = 32'h1FC;
    tick();
    n_checks++; if (Instruction !== ref_word(32'h1FC)) begin n_errors++; $display("FAIL midrst_fetch_last: got %h expected %h", Instruction, ref_word(32'h1FC)); end
    FetchReq = 1'b0;
    tick();
  endtask

`ifdef INSTR_MEM_PARITY_EN
  task automatic test_parity();
    LoadStart = 1'b1;
    tick();
    LoadStart = 1'b0;
    LoadValid = 1'b1; LoadData = 32'h1234_5678;
    tick();
    LoadData = 32'h0F0F_0001; LoadEnd = 1'b1;
    tick();
    LoadValid = 1'b0; LoadEnd = 1'b0;
    dut.mem[1] = dut.mem[1] ^ 32'h0000_0100;
    FetchReq = 1'b1; Address = 32'h4;
    tick();
    n_checks++; if (ParityErr !== 1'b1) begin n_errors++; $display("FAIL parity_flag: got %b expected 1", ParityErr); end
    n_checks++; if (Instruction !== NOP) begin n_errors++; $display("FAIL parity_instr: got %h expected %h", Instruction, NOP); end
    n_checks++; if (InstrValid !== 1'b1) begin n_errors++; $display("FAIL parity_valid: got %b expected 1", InstrValid); end
    FetchStall = 1'b1; Address = 32'h0;
    tick();
    n_checks++; if (ParityErr !== 1'b1) begin n_errors++; $display("FAIL parity_hold: got %b expected 1", ParityErr); end
    FetchStall = 1'b0;
    tick();
    n_checks++; if (ParityErr !== 1'b0) begin n_errors++; $display("FAIL parity_clear: got %b expected 0", ParityErr); end
    n_checks++; if (Instruction !== 32'h1234_5678) begin n_errors++; $display("FAIL parity_good_word: got %h expected %h", Instruction, 32'h1234_5678); end
    FetchReq = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load_end();
    test_faults();
    test_stall();
    test_full_load();
    test_random_traffic();
    test_reset_mid_load();
`ifdef INSTR_MEM_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
